// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU: radix-2 shift-add multiply,
// restoring divide, sign fix-up, and a pipeline stall request while an op is in flight.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      counter_q, counter_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               fix_step_q, fix_step_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   prev_result_q, prev_result_d;

    logic               a_signed_s, b_signed_s, sa_s, sb_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic               div_zero_s, div_ovf_s, special_s;
    logic [WIDTH-1:0]   special_val_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] signed_acc_s;
    logic [WIDTH-1:0]   fin_s;
    logic               stall_s;

    // Operand decode at acceptance: signedness, magnitudes, and the divide corner cases.
    always_comb begin
        a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa_s       = a_signed_s & a[WIDTH-1];
        sb_s       = b_signed_s & b[WIDTH-1];
        mag_a_s    = sa_s ? neg_w(a) : a;
        mag_b_s    = sb_s ? neg_w(b) : b;
        div_zero_s = op[2] && (b == {WIDTH{1'b0}});
        div_ovf_s  = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
        special_s  = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_val_s = op[1] ? a : {WIDTH{1'b1}};
        end else begin
            special_val_s = op[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply or restoring divide, plus the sign fix-up value.
    always_comb begin
        mul_sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        div_shift_s  = {rem_q, acc_q[WIDTH-1]};
        div_diff_s   = div_shift_s - {1'b0, opb_q};
        signed_acc_s = neg_q ? neg_2w(acc_q) : acc_q;
        case (op_q)
            3'b000:  fin_s = signed_acc_s[WIDTH-1:0];
            3'b001,
            3'b010,
            3'b011:  fin_s = signed_acc_s[2*WIDTH-1:WIDTH];
            3'b100,
            3'b101:  fin_s = signed_acc_s[WIDTH-1:0];
            default: fin_s = rem_neg_q ? neg_w(rem_q) : rem_q;
        endcase
    end

    // Sequencer next-state, datapath register updates and stall request.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        op_d          = op_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        acc_d         = acc_q;
        rem_d         = rem_q;
        neg_d         = neg_q;
        rem_neg_d     = rem_neg_q;
        fix_step_d    = fix_step_q;
        result_d      = result_q;
        prev_result_d = prev_result_q;
        stall_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_s = start & ~flush;
                if (start && !flush) begin
                    op_d       = op;
                    opa_d      = mag_a_s;
                    opb_d      = mag_b_s;
                    neg_d      = sa_s ^ sb_s;
                    rem_neg_d  = sa_s;
                    counter_d  = {CW{1'b0}};
                    fix_step_d = 1'b0;
                    rem_d      = {WIDTH{1'b0}};
                    // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
                    acc_d      = {{WIDTH{1'b0}}, (op[2] ? mag_a_s : mag_b_s)};
                    if (special_s) begin
                        prev_result_d = result_q;
                        result_d      = special_val_s;
                        state_d       = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                stall_s = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        if (!div_diff_s[WIDTH]) begin
                            rem_d = div_diff_s[WIDTH-1:0];
                        end else begin
                            rem_d = div_shift_s[WIDTH-1:0];
                        end
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
                    end else begin
                        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                    end
                    if (counter_q == CW'(WIDTH-1)) begin
                        state_d    = S_FIX;
                        fix_step_d = 1'b0;
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            S_FIX: begin
                stall_s = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!fix_step_q) begin
                    acc_d      = {{WIDTH{1'b0}}, fin_s};
                    fix_step_d = 1'b1;
                end else begin
                    prev_result_d = result_q;
                    result_d      = acc_q[WIDTH-1:0];
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                stall_s = 1'b0;
                state_d = S_IDLE;
                // A flushed op must not leave its value behind.
                if (flush) begin
                    result_d = prev_result_q;
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            counter_q     <= {CW{1'b0}};
            op_q          <= 3'b000;
            opa_q         <= {WIDTH{1'b0}};
            opb_q         <= {WIDTH{1'b0}};
            acc_q         <= {(2*WIDTH){1'b0}};
            rem_q         <= {WIDTH{1'b0}};
            neg_q         <= 1'b0;
            rem_neg_q     <= 1'b0;
            fix_step_q    <= 1'b0;
            result_q      <= {WIDTH{1'b0}};
            prev_result_q <= {WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            op_q          <= op_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            acc_q         <= acc_d;
            rem_q         <= rem_d;
            neg_q         <= neg_d;
            rem_neg_q     <= rem_neg_d;
            fix_step_q    <= fix_step_d;
            result_q      <= result_d;
            prev_result_q <= prev_result_d;
        end
    end

    assign stall_req = stall_s;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) && !flush;
    assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: arithmetic reference model plus cycle timing expectations,
// checked every cycle, with directed RV32M vectors and literal expected results.
module tb_ex_muldiv_sequencer;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = 32'h0;
    logic [W-1:0] b     = 32'h0;
    logic         stall_req, busy, done;
    logic [W-1:0] result;

    ex_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit           op_live  = 1'b0;
    int           acc_cyc  = 0;
    int           lat      = 0;
    logic [W-1:0] exp_res  = 32'h0;
    logic [W-1:0] held_res = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sx, sy, sp, sq;
        logic [63:0]        ux, uy, up;
        sx = 64'($signed(x));
        sy = 64'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            3'd0: begin up = ux * uy; return up[31:0]; end
            3'd1: begin sp = sx * sy; return sp[63:32]; end
            3'd2: begin sp = sx * $signed(uy); return sp[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sx / sy;
                return sq[31:0];
            end
            3'd5: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                up = ux / uy;
                return up[31:0];
            end
            3'd6: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                sq = sx % sy;
                return sq[31:0];
            end
            default: begin
                if (y == 32'h0) return x;
                up = ux % uy;
                return up[31:0];
            end
        endcase
    endfunction

    // Per-cycle compare of all outputs against the timing/result expectations.
    always @(negedge clk) begin
        bit eb, ed, es;
        eb = op_live && (cyc >= acc_cyc) && (cyc <= acc_cyc + lat);
        ed = eb && (cyc == acc_cyc + lat) && !flush;
        es = (op_live && (cyc >= acc_cyc) && (cyc < acc_cyc + lat)) || (start && !flush && !eb);
        if (!rst_n) held_res = 32'h0;
        else if (ed) held_res = exp_res;
        check1("busy", busy, eb);
        check1("done", done, ed);
        check1("stall_req", stall_req, es);
        check("result", result, held_res);
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] lit, input string name);
        logic [W-1:0] m;
        bit           sp;
        m  = model(o, x, y);
        check({name, "/model"}, m, lit);
        sp = o[2] && ((y == 32'h0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc; lat = sp ? 0 : 34; exp_res = m; op_live = 1'b1;
        start = 1'b0; a = ~x; b = $urandom; op = ~o;
        if (!sp) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            repeat (3) @(posedge clk);
            #1 start = 1'b0;
        end
        while (cyc < acc_cyc + lat + 1) begin
            @(posedge clk); #1;
        end
        op_live = 1'b0;
        check({name, "/result"}, result, lit);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check1("reset/busy", busy, 1'b0);
        check1("reset/done", done, 1'b0);
        check("reset/result", result, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULH min*min");
        run_op(3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULHU");
        run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "MULHSU -1*2");
        run_op(3'd0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, "MUL 2^32");
        run_op(3'd1, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, "MULH -3*5");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7%2");
        run_op(3'd5, 32'd100,        32'd7,         32'd14,        "DIVU 100/7");
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         "REMU 100%7");
        run_op(3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2");
        run_op(3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         "REM 7%-2");
        run_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIV 5/0");
        run_op(3'd6, 32'd5,          32'd0,         32'd5,         "REM 5/0");
        run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIVU 5/0");
        run_op(3'd7, 32'd5,          32'd0,         32'd5,         "REMU 5/0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "REM ovf");

        // start together with flush in IDLE is ignored
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check1("idle flush/busy", busy, 1'b0);

        // flush mid-CALC at counter=10
        op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc; lat = 34; exp_res = model(3'd5, 32'd1000, 32'd3); op_live = 1'b1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; op_live = 1'b0;
        check1("flush/busy", busy, 1'b0);
        check("flush/result", result, 32'h0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, "MUL 3*4 after flush");

        // asynchronous reset mid-CALC at counter=20
        op = 3'd5; a = 32'hFFFF_FFF0; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc; lat = 34; exp_res = model(3'd5, 32'hFFFF_FFF0, 32'd5); op_live = 1'b1; start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check1("pre-reset/busy", busy, 1'b1);
        rst_n = 1'b0; op_live = 1'b0;
        #1;
        check1("async reset/busy", busy, 1'b0);
        check1("async reset/done", done, 1'b0);
        check("async reset/result", result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd5, 32'hFFFF_FFF0, 32'd5, 32'h3333_3330, "DIVU after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
